if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 113 +++++++++++
 tb/tb_if_id_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: a single-outstanding fetch FSM feeding a small FIFO
// of {pc, pc+4, instruction} entries toward decode.

module if_id_slot #(
  parameter int W = 96
) (
  input  logic         CLK,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage keeps its contents across reset and flush; only the pointers and
  // the count decide what is visible.
  always_ff @(posedge CLK) begin
    if (we) q <= d;
  end
endmodule

module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic [31:0] PC_4,
  output logic        BUSY_WAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        ID_STALL,
  input  logic        FLUSH,
  output logic        VALID,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_4
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] instr;
  } entry_t;

  logic [0:0]    state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          complete, push, pop;
  entry_t        wr_entry, head;
  entry_t [DEPTH-1:0] slot_q;

  // A fetch that lands in the same cycle as a flush is dropped on the floor.
  assign complete  = (state == REQ) && !IMEM_BUSYWAIT && !FLUSH;
  assign push      = complete;
  assign pop       = (count != '0) && !ID_STALL && !FLUSH;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_nxt = IDLE;
    if (FLUSH)
      state_nxt = IDLE;
    else if ((state == REQ) && IMEM_BUSYWAIT)
      state_nxt = REQ;
    else if (count_nxt < DEPTH_C)
      state_nxt = REQ;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  assign wr_entry = '{pc: PC, pc_4: PC_4, instr: IMEM_READDATA};

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if_id_slot #(.W($bits(entry_t))) u_slot (
      .CLK (CLK),
      .we  (push && (wr_ptr == AW'(i))),
      .d   (wr_entry),
      .q   (slot_q[i])
    );
  end

  assign head = slot_q[rd_ptr];

  assign IMEM_READ    = (state == REQ);
  assign IMEM_ADDRESS = PC;
  assign BUSY_WAIT    = !complete;
  assign VALID        = (count != '0);
  assign INSTRUCTION  = VALID ? head.instr : NOP_INSTR;
  assign ID_PC        = VALID ? head.pc    : 32'h0;
  assign ID_PC_4      = VALID ? head.pc_4  : 32'h0;
endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: cycle table for directed corners plus a scoreboard
// fed by a PC-unit / instruction-memory model.

module tb_if_id_buffer;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, pc_4;
  logic        busy_wait, imem_read;
  logic [31:0] imem_address, imem_readdata;
  logic        imem_busywait, id_stall, flush;
  logic        valid;
  logic [31:0] instruction, id_pc, id_pc_4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit          stall, mb, fl;
    bit          rd, bw, vld;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[21];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : {a[15:0], 16'h0113};
  endfunction

  always #5 clk = ~clk;
  assign pc_4          = pc + 32'd4;
  assign imem_readdata = mem_f(imem_address);

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .CLK           (clk),
    .RESET         (reset),
    .PC            (pc),
    .PC_4          (pc_4),
    .BUSY_WAIT     (busy_wait),
    .IMEM_READ     (imem_read),
    .IMEM_ADDRESS  (imem_address),
    .IMEM_READDATA (imem_readdata),
    .IMEM_BUSYWAIT (imem_busywait),
    .ID_STALL      (id_stall),
    .FLUSH         (flush),
    .VALID         (valid),
    .INSTRUCTION   (instruction),
    .ID_PC         (id_pc),
    .ID_PC_4       (id_pc_4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Scoreboard step, taken mid-cycle: decisions reflect the upcoming edge.
  task automatic monitor(output bit adv);
    adv = 1'b0;
    check("imem_address", imem_address, pc);
    check1("valid_vs_model", valid, q.size() != 0);
    if (q.size() != 0) begin
      check("instruction", instruction, q[0].instr);
      check("id_pc", id_pc, q[0].pc);
      check("id_pc_4", id_pc_4, q[0].pc4);
    end else begin
      check("instruction_empty", instruction, NOP);
      check("id_pc_empty", id_pc, 32'h0);
      check("id_pc_4_empty", id_pc_4, 32'h0);
    end
    if (flush) begin
      check1("busy_wait_on_flush", busy_wait, 1'b1);
      q.delete();
    end else begin
      if (valid && !id_stall && q.size() != 0) void'(q.pop_front());
      if (!busy_wait) begin
        q.push_back('{pc: pc, pc4: pc + 32'd4, instr: mem_f(pc)});
        adv = 1'b1;
      end
      check1("occupancy_le_depth", q.size() <= DEPTH, 1'b1);
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit chk);
    bit adv;
    id_stall      = v.stall;
    imem_busywait = v.mb;
    flush         = v.fl;
    @(negedge clk);
    if (chk) begin
      check1("imem_read", imem_read, v.rd);
      check1("busy_wait", busy_wait, v.bw);
      check1("valid", valid, v.vld);
      check("pc_addr", imem_address, v.addr);
    end
    monitor(adv);
    @(posedge clk);
    #1;
    if (adv) pc = pc + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    //            stall mb fl  rd bw vld addr
    vecs[0]  = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 32'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 32'd4};
    vecs[3]  = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 32'd8};
    vecs[4]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1, 32'd12};
    vecs[5]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 32'd12};
    vecs[6]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 32'd12};
    vecs[7]  = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'd12};
    vecs[8]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1, 32'd16};
    vecs[9]  = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 32'd20};
    vecs[10] = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 32'd20};
    vecs[11] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1, 32'd20};
    vecs[12] = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 32'd20};
    vecs[13] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,1'b1, 32'd24};
    vecs[14] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 32'd24};
    vecs[15] = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'd24};
    vecs[16] = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 32'd28};
    vecs[17] = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1, 32'd32};
    vecs[18] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 32'd32};
    vecs[19] = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 32'd32};
    vecs[20] = '{1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1, 32'd36};

    reset = 1'b0; pc = 32'd0;
    id_stall = 1'b0; imem_busywait = 1'b0; flush = 1'b0;
    @(negedge clk);
    check1("rst_imem_read", imem_read, 1'b0);
    check1("rst_busy_wait", busy_wait, 1'b1);
    check1("rst_valid", valid, 1'b0);
    check("rst_instruction", instruction, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc_4", id_pc_4, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 20; i++) run_cycle(vecs[i], 1'b1);

    // Reset dropped between edges while a fetch is pending and an entry is held.
    id_stall = vecs[20].stall; imem_busywait = vecs[20].mb; flush = vecs[20].fl;
    @(negedge clk);
    check1("imem_read", imem_read, vecs[20].rd);
    check1("busy_wait", busy_wait, vecs[20].bw);
    check1("valid", valid, vecs[20].vld);
    check("pc_addr", imem_address, vecs[20].addr);
    #2 reset = 1'b0;
    #1;
    check1("async_rst_imem_read", imem_read, 1'b0);
    check1("async_rst_valid", valid, 1'b0);
    check1("async_rst_busy_wait", busy_wait, 1'b1);
    check("async_rst_instruction", instruction, NOP);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      rv.stall = ($urandom_range(3) == 0);
      rv.mb    = ($urandom_range(2) == 0);
      rv.fl    = ($urandom_range(15) == 0);
      rv.rd = 1'b0; rv.bw = 1'b0; rv.vld = 1'b0; rv.addr = 32'h0;
      run_cycle(rv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
